// File: rtl/issue_pkg.sv
// Shared defaults, the "no dependency" ROB index, and the issue payload layout.
package issue_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int ROB_W_DEF = 6;
    localparam int OPC_W_DEF = 6;
    localparam int REG_W_DEF = 5;

    // ROB entry 0 is never allocated, so it doubles as "no producer".
    localparam logic [ROB_W_DEF-1:0] ROB_NONE = '0;

    // Payload shared by the reservation station and the load/store buffer.
    typedef struct packed {
        logic [OPC_W_DEF-1:0] opcode;
        logic [XLEN_DEF-1:0]  val1;
        logic [XLEN_DEF-1:0]  val2;
        logic [ROB_W_DEF-1:0] dep1;
        logic [ROB_W_DEF-1:0] dep2;
        logic                 has_dep1;
        logic                 has_dep2;
        logic [ROB_W_DEF-1:0] rob_index;
        logic [XLEN_DEF-1:0]  imm;
        logic [XLEN_DEF-1:0]  pc;
    } issue_payload_t;

endpackage

// File: rtl/operand_resolver.sv
// Resolves one source operand: x0, register file, CDB bypass, ROB value, or a pending tag.
module operand_resolver
    import issue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ROB_W = ROB_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] rs,
    input  logic [XLEN-1:0]  rf_val,
    input  logic [ROB_W-1:0] rf_dep,
    input  logic             rf_has_dep,
    input  logic             rob_value_valid,
    input  logic [XLEN-1:0]  rob_value,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_index,
    input  logic [XLEN-1:0]  cdb_value,
    output logic [XLEN-1:0]  val,
    output logic [ROB_W-1:0] dep,
    output logic             has_dep
);

    // Priority chain; the CDB is checked before the ROB so a same-cycle broadcast is never missed.
    always_comb begin
        val     = '0;
        dep     = '0;
        has_dep = 1'b0;
        if (rs == '0) begin
            val = '0;
        end else if (!rf_has_dep) begin
            val = rf_val;
        end else if (cdb_valid && (cdb_rob_index == rf_dep)) begin
            val = cdb_value;
        end else if (rob_value_valid) begin
            val = rob_value;
        end else begin
            has_dep = 1'b1;
            dep     = rf_dep;
        end
    end

endmodule

// File: rtl/issue_stage.sv
// In-order issue: handshake, operand resolution, ROB/RF allocation and registered dispatch.
module issue_stage
    import issue_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ROB_W = ROB_W_DEF,
    parameter int OPC_W = OPC_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [REG_W-1:0] in_rs1,
    input  logic [REG_W-1:0] in_rs2,
    input  logic [REG_W-1:0] in_rd,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic             in_jumped,
    input  logic             in_is_mem,
    input  logic             in_writes_rd,
    input  logic [ROB_W-1:0] rob_next_index,
    input  logic             rob_full,
    input  logic             rs_full,
    input  logic             lsb_full,
    output logic [REG_W-1:0] rf_check1,
    output logic [REG_W-1:0] rf_check2,
    input  logic [XLEN-1:0]  rf_val1,
    input  logic [XLEN-1:0]  rf_val2,
    input  logic [ROB_W-1:0] rf_dep1,
    input  logic [ROB_W-1:0] rf_dep2,
    input  logic             rf_has_dep1,
    input  logic             rf_has_dep2,
    output logic [ROB_W-1:0] rob_check1,
    output logic [ROB_W-1:0] rob_check2,
    input  logic             rob_value_valid1,
    input  logic             rob_value_valid2,
    input  logic [XLEN-1:0]  rob_value1,
    input  logic [XLEN-1:0]  rob_value2,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_rob_index,
    input  logic [XLEN-1:0]  cdb_value,
    output logic             rob_valid,
    output logic [REG_W-1:0] rob_rd,
    output logic             rob_jumped,
    output logic [XLEN-1:0]  rob_pc,
    output logic             rob_is_mem,
    output logic             rs_valid,
    output logic             lsb_valid,
    output logic [OPC_W-1:0] iss_opcode,
    output logic [XLEN-1:0]  iss_val1,
    output logic [XLEN-1:0]  iss_val2,
    output logic [ROB_W-1:0] iss_dep1,
    output logic [ROB_W-1:0] iss_dep2,
    output logic             iss_has_dep1,
    output logic             iss_has_dep2,
    output logic [ROB_W-1:0] iss_rob_index,
    output logic [XLEN-1:0]  iss_imm,
    output logic [XLEN-1:0]  iss_pc,
    output logic             rf_valid,
    output logic [REG_W-1:0] rf_regname,
    output logic [ROB_W-1:0] rf_regrename
);

    logic             fire;
    logic [XLEN-1:0]  res_val1, res_val2;
    logic [ROB_W-1:0] res_dep1, res_dep2;
    logic             res_has_dep1, res_has_dep2;

    assign rf_check1  = in_rs1;
    assign rf_check2  = in_rs2;
    assign rob_check1 = rf_dep1;
    assign rob_check2 = rf_dep2;

    // Accept only when the destination queue for this instruction class has room.
    assign in_ready = rdy & ~flush & ~rob_full & (in_is_mem ? ~lsb_full : ~rs_full);
    assign fire     = in_valid & in_ready;

    operand_resolver #(.XLEN(XLEN), .ROB_W(ROB_W), .REG_W(REG_W)) u_res1 (
        .rs(in_rs1), .rf_val(rf_val1), .rf_dep(rf_dep1), .rf_has_dep(rf_has_dep1),
        .rob_value_valid(rob_value_valid1), .rob_value(rob_value1),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
        .val(res_val1), .dep(res_dep1), .has_dep(res_has_dep1)
    );

    operand_resolver #(.XLEN(XLEN), .ROB_W(ROB_W), .REG_W(REG_W)) u_res2 (
        .rs(in_rs2), .rf_val(rf_val2), .rf_dep(rf_dep2), .rf_has_dep(rf_has_dep2),
        .rob_value_valid(rob_value_valid2), .rob_value(rob_value2),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
        .val(res_val2), .dep(res_dep2), .has_dep(res_has_dep2)
    );

    // Strobes pulse for one cycle per fire; payload registers only load on fire; rdy low freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            rob_valid     <= 1'b0;
            rs_valid      <= 1'b0;
            lsb_valid     <= 1'b0;
            rf_valid      <= 1'b0;
            rob_rd        <= '0;
            rob_jumped    <= 1'b0;
            rob_pc        <= '0;
            rob_is_mem    <= 1'b0;
            iss_opcode    <= '0;
            iss_val1      <= '0;
            iss_val2      <= '0;
            iss_dep1      <= '0;
            iss_dep2      <= '0;
            iss_has_dep1  <= 1'b0;
            iss_has_dep2  <= 1'b0;
            iss_rob_index <= '0;
            iss_imm       <= '0;
            iss_pc        <= '0;
            rf_regname    <= '0;
            rf_regrename  <= '0;
        end else if (rdy) begin
            rob_valid <= fire;
            rs_valid  <= fire & ~in_is_mem;
            lsb_valid <= fire & in_is_mem;
            rf_valid  <= fire & in_writes_rd & (in_rd != '0);
            if (fire) begin
                rob_rd        <= in_rd;
                rob_jumped    <= in_jumped;
                rob_pc        <= in_pc;
                rob_is_mem    <= in_is_mem;
                iss_opcode    <= in_opcode;
                iss_val1      <= res_val1;
                iss_val2      <= res_val2;
                iss_dep1      <= res_dep1;
                iss_dep2      <= res_dep2;
                iss_has_dep1  <= res_has_dep1;
                iss_has_dep2  <= res_has_dep2;
                iss_rob_index <= rob_next_index;
                iss_imm       <= in_imm;
                iss_pc        <= in_pc;
                rf_regname    <= in_rd;
                rf_regrename  <= rob_next_index;
            end
        end
    end

endmodule

// File: tb/tb_issue_stage.sv
// Directed-vector bench for issue_stage with hand-computed expectations.
module tb_issue_stage;

    localparam int XLEN = 32, ROB_W = 6, OPC_W = 6, REG_W = 5;

    logic             clk = 1'b0;
    logic             rst, rdy, flush, in_valid, in_ready;
    logic [OPC_W-1:0] in_opcode;
    logic [REG_W-1:0] in_rs1, in_rs2, in_rd;
    logic [XLEN-1:0]  in_imm, in_pc;
    logic             in_jumped, in_is_mem, in_writes_rd;
    logic [ROB_W-1:0] rob_next_index;
    logic             rob_full, rs_full, lsb_full;
    logic [REG_W-1:0] rf_check1, rf_check2;
    logic [XLEN-1:0]  rf_val1, rf_val2;
    logic [ROB_W-1:0] rf_dep1, rf_dep2;
    logic             rf_has_dep1, rf_has_dep2;
    logic [ROB_W-1:0] rob_check1, rob_check2;
    logic             rob_value_valid1, rob_value_valid2;
    logic [XLEN-1:0]  rob_value1, rob_value2;
    logic             cdb_valid;
    logic [ROB_W-1:0] cdb_rob_index;
    logic [XLEN-1:0]  cdb_value;
    logic             rob_valid, rob_jumped, rob_is_mem;
    logic [REG_W-1:0] rob_rd;
    logic [XLEN-1:0]  rob_pc;
    logic             rs_valid, lsb_valid;
    logic [OPC_W-1:0] iss_opcode;
    logic [XLEN-1:0]  iss_val1, iss_val2, iss_imm, iss_pc;
    logic [ROB_W-1:0] iss_dep1, iss_dep2, iss_rob_index;
    logic             iss_has_dep1, iss_has_dep2;
    logic             rf_valid;
    logic [REG_W-1:0] rf_regname;
    logic [ROB_W-1:0] rf_regrename;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_stage #(.XLEN(XLEN), .ROB_W(ROB_W), .OPC_W(OPC_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_pc(in_pc), .in_jumped(in_jumped), .in_is_mem(in_is_mem),
        .in_writes_rd(in_writes_rd), .rob_next_index(rob_next_index),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .rf_check1(rf_check1), .rf_check2(rf_check2),
        .rf_val1(rf_val1), .rf_val2(rf_val2), .rf_dep1(rf_dep1), .rf_dep2(rf_dep2),
        .rf_has_dep1(rf_has_dep1), .rf_has_dep2(rf_has_dep2),
        .rob_check1(rob_check1), .rob_check2(rob_check2),
        .rob_value_valid1(rob_value_valid1), .rob_value_valid2(rob_value_valid2),
        .rob_value1(rob_value1), .rob_value2(rob_value2),
        .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
        .rob_valid(rob_valid), .rob_rd(rob_rd), .rob_jumped(rob_jumped),
        .rob_pc(rob_pc), .rob_is_mem(rob_is_mem),
        .rs_valid(rs_valid), .lsb_valid(lsb_valid),
        .iss_opcode(iss_opcode), .iss_val1(iss_val1), .iss_val2(iss_val2),
        .iss_dep1(iss_dep1), .iss_dep2(iss_dep2),
        .iss_has_dep1(iss_has_dep1), .iss_has_dep2(iss_has_dep2),
        .iss_rob_index(iss_rob_index), .iss_imm(iss_imm), .iss_pc(iss_pc),
        .rf_valid(rf_valid), .rf_regname(rf_regname), .rf_regrename(rf_regrename)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_pc = '0; in_jumped = 1'b0; in_is_mem = 1'b0; in_writes_rd = 1'b0;
        rob_next_index = '0; rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        rf_val1 = '0; rf_val2 = '0; rf_dep1 = '0; rf_dep2 = '0;
        rf_has_dep1 = 1'b0; rf_has_dep2 = 1'b0;
        rob_value_valid1 = 1'b0; rob_value_valid2 = 1'b0; rob_value1 = '0; rob_value2 = '0;
        cdb_valid = 1'b0; cdb_rob_index = '0; cdb_value = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step(); step();
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_rob_valid", rob_valid, 0);
        chk("rst_iss_val1", iss_val1, 0);
        chk("rst_rf_regrename", rf_regrename, 0);
        rst = 1'b0;

        // Independent operands to the RS
        in_valid = 1; in_rs1 = 3; in_rs2 = 4; in_rd = 2; in_writes_rd = 1;
        rf_val1 = 32'h10; rf_val2 = 32'h20; rob_next_index = 5;
        in_opcode = 6'h0C; in_imm = 32'h44; in_pc = 32'h1000; in_jumped = 1;
        rf_dep1 = 6'd11;
        #1;
        chk("ind_in_ready", in_ready, 1);
        chk("ind_rf_check1", rf_check1, 3);
        chk("ind_rob_check1", rob_check1, 11);
        step();
        chk("ind_rs_valid", rs_valid, 1);
        chk("ind_lsb_valid", lsb_valid, 0);
        chk("ind_rob_valid", rob_valid, 1);
        chk("ind_rf_valid", rf_valid, 1);
        chk("ind_val1", iss_val1, 32'h10);
        chk("ind_val2", iss_val2, 32'h20);
        chk("ind_has_dep1", iss_has_dep1, 0);
        chk("ind_has_dep2", iss_has_dep2, 0);
        chk("ind_regrename", rf_regrename, 5);
        chk("ind_rob_index", iss_rob_index, 5);
        chk("ind_regname", rf_regname, 2);
        chk("ind_rob_pc", rob_pc, 32'h1000);
        chk("ind_rob_jumped", rob_jumped, 1);
        chk("ind_opcode", iss_opcode, 6'h0C);
        in_valid = 0;
        step();
        chk("pulse_rs_valid", rs_valid, 0);
        chk("pulse_rob_valid", rob_valid, 0);
        chk("hold_val1", iss_val1, 32'h10);

        // ROB stall then release
        in_valid = 1; rob_full = 1; rob_next_index = 6; rf_val1 = 32'h77;
        #1;
        chk("stall_in_ready", in_ready, 0);
        step();
        chk("stall_rs_valid", rs_valid, 0);
        chk("stall_hold_val1", iss_val1, 32'h10);
        rob_full = 0;
        step();
        chk("rel_rs_valid", rs_valid, 1);
        chk("rel_val1", iss_val1, 32'h77);
        chk("rel_regrename", rf_regrename, 6);

        // CDB bypass on source 1
        rf_has_dep1 = 1; rf_dep1 = 7; rob_value_valid1 = 0;
        cdb_valid = 1; cdb_rob_index = 7; cdb_value = 32'hABCD;
        step();
        chk("cdb_val1", iss_val1, 32'hABCD);
        chk("cdb_has_dep1", iss_has_dep1, 0);
        chk("cdb_dep1", iss_dep1, 0);

        // Unresolved dependency
        cdb_rob_index = 9;
        step();
        chk("dep_has_dep1", iss_has_dep1, 1);
        chk("dep_dep1", iss_dep1, 7);
        chk("dep_val1", iss_val1, 0);

        // ROB already holds the value
        rob_value_valid1 = 1; rob_value1 = 32'h55;
        step();
        chk("robv_val1", iss_val1, 32'h55);
        chk("robv_has_dep1", iss_has_dep1, 0);
        rob_value_valid1 = 0; cdb_valid = 0;

        // Store to LSB, rs1 = x0 with a stale RF dependency
        in_is_mem = 1; in_writes_rd = 0; in_rs1 = 0; rf_has_dep1 = 1; rf_dep1 = 7;
        step();
        chk("st_lsb_valid", lsb_valid, 1);
        chk("st_rs_valid", rs_valid, 0);
        chk("st_rf_valid", rf_valid, 0);
        chk("st_val1", iss_val1, 0);
        chk("st_has_dep1", iss_has_dep1, 0);
        chk("st_rob_is_mem", rob_is_mem, 1);

        // Full-flag routing
        lsb_full = 1;
        #1;
        chk("lsbfull_ready", in_ready, 0);
        rs_full = 1; lsb_full = 0;
        #1;
        chk("rsfull_mem_ready", in_ready, 1);
        in_is_mem = 0;
        #1;
        chk("rsfull_alu_ready", in_ready, 0);
        rs_full = 0;

        // Writes rd = x0: no rename
        in_writes_rd = 1; in_rd = 0; in_rs1 = 3; rf_has_dep1 = 0;
        step();
        chk("x0rd_rf_valid", rf_valid, 0);
        chk("x0rd_rs_valid", rs_valid, 1);

        // Flush beats in_valid
        flush = 1;
        #1;
        chk("flush_ready", in_ready, 0);
        step();
        chk("flush_rs_valid", rs_valid, 0);
        chk("flush_rob_valid", rob_valid, 0);
        flush = 0;

        // Fire, then freeze for 3 cycles
        in_rd = 4; rob_next_index = 9;
        step();
        chk("frz_fire_rs_valid", rs_valid, 1);
        rdy = 0; in_rs1 = 5; rf_val1 = 32'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("frz_rs_valid%0d", i), rs_valid, 1);
            chk($sformatf("frz_rf_valid%0d", i), rf_valid, 1);
            chk($sformatf("frz_regrename%0d", i), rf_regrename, 9);
        end
        chk("frz_ready", in_ready, 0);

        // Reset overrides rdy low and pending strobes
        rst = 1;
        step();
        chk("rst2_rs_valid", rs_valid, 0);
        chk("rst2_rf_valid", rf_valid, 0);
        chk("rst2_rob_valid", rob_valid, 0);
        chk("rst2_rob_pc", rob_pc, 0);
        chk("rst2_regrename", rf_regrename, 0);
        chk("rst2_val1", iss_val1, 0);
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
# issue_stage

Parametrised in-order issue stage between the decoder/fetch front end and the out-of-order back end. Each cycle it accepts at most one decoded instruction, resolves both source operands, allocates the next ROB entry, renames `rd` in the register file, and dispatches a registered packet to either the reservation station (ALU/branch) or the load/store buffer. It adds backpressure, memory/ALU routing, CDB bypass and x0 handling.

## Interface
Parameters:
- `XLEN`, 32: data and PC width.
- `ROB_W`, 6: ROB index width; index 0 is never allocated and means "no dependency".
- `OPC_W`, 6: internal opcode width.
- `REG_W`, 5: architectural register index width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rdy`  in  1  global enable; low freezes all state.
- `flush`  in  1  misprediction flush from the commit stage.
- `in_valid` / `in_ready`  in / out  1 / 1  decoded-instruction handshake.
- `in_opcode`, `in_rs1`, `in_rs2`, `in_rd`  in  OPC_W, REG_W ×3  decoded fields.
- `in_imm`, `in_pc`  in  XLEN each  immediate and PC.
- `in_jumped`  in  1  predictor took the branch.
- `in_is_mem`  in  1  route the instruction to the LSB.
- `in_writes_rd`  in  1  the instruction writes `rd`.
- `rob_next_index`  in  ROB_W  ROB entry to allocate.
- `rob_full`, `rs_full`, `lsb_full`  in  1 each  no free slot next cycle.
- `rf_check1/2`  out  REG_W  RF lookup addresses; equal to `in_rs1/2`.
- `rf_val1/2`, `rf_dep1/2`, `rf_has_dep1/2`  in  XLEN, ROB_W, 1  RF lookup results.
- `rob_check1/2`  out  ROB_W  ROB lookups; equal to `rf_dep1/2`.
- `rob_value_valid1/2`, `rob_value1/2`  in  1, XLEN  ROB lookup results.
- `cdb_valid`, `cdb_rob_index`, `cdb_value`  in  1, ROB_W, XLEN  result broadcast this cycle.
- `rob_valid`, `rob_rd`, `rob_jumped`, `rob_pc`, `rob_is_mem`  out  1, REG_W, 1, XLEN, 1  ROB allocation.
- `rs_valid`, `lsb_valid`  out  1 each  dispatch strobes; mutually exclusive.
- `iss_opcode`, `iss_val1/2`, `iss_dep1/2`, `iss_has_dep1/2`, `iss_rob_index`, `iss_imm`, `iss_pc`  out  OPC_W, XLEN, ROB_W, 1, ROB_W, XLEN, XLEN  shared RS/LSB payload.
- `rf_valid`, `rf_regname`, `rf_regrename`  out  1, REG_W, ROB_W  rename write.

## Operation
- `in_ready = rdy & ~flush & ~rob_full & (in_is_mem ? ~lsb_full : ~rs_full)`.
- `fire = in_valid & in_ready`.
- Operand resolution, per source, in priority order:
  1. Register index 0: value 0, no dependency.
  2. `~rf_has_dep`: `rf_val`.
  3. CDB hit (`cdb_valid` and `cdb_rob_index == rf_dep`): `cdb_value`, no dependency.
  4. `rob_value_valid`: `rob_value`, no dependency.
  5. Otherwise: value 0, `has_dep = 1`, `dep = rf_dep`.
- When no dependency remains, `dep` is 0.
- On fire:
  - Register the payload and pulse `rob_valid`.
  - Pulse `rs_valid` if `~in_is_mem`, else `lsb_valid`.
  - Pulse `rf_valid` only if `in_writes_rd` and `in_rd != 0`.
  - `iss_rob_index = rf_regrename = rob_next_index`.
- No fire (and `rdy` high): all strobes go to 0 next edge; payload registers hold.
- `flush` (and `rdy` high): all strobes go to 0 next edge and the incoming instruction is dropped. Flush beats `in_valid`.
- `rdy` low: every register holds, including strobes.
- The `*_full` flags must already account for the entry dispatched in the previous cycle. The downstream blocks are responsible for this.

## Timing
- Latency: one cycle from fire to strobes. Each strobe is high for exactly one cycle per fire.
- Back-to-back fires are allowed, giving a throughput of one instruction per cycle.
- `in_ready`, `rf_check*` and `rob_check*` are combinational. There is no path from strobe outputs to `in_ready`.
- Reset, at the next edge: all strobes 0; every payload, rename and ROB output 0. `rst` overrides `rdy` and `flush`.
- Reset asserted mid-dispatch clears the pending strobes at that edge.
- A CDB broadcast in the same cycle as the RF/ROB lookup is captured, so there is no lost wakeup.

## Structure
- Shared package `issue_pkg`: defaults for `XLEN`, `ROB_W`, `OPC_W`, `REG_W`, the constant `ROB_NONE = 0`, and the issue-payload struct.
- Sub-module `operand_resolver` implements the priority chain above and is instantiated twice.
- The top level holds only the handshake logic and output registers.

## Test plan
- **Independent operands:** rs1=3 (`rf_val1`=0x10), rs2=4 (`rf_val2`=0x20), `in_is_mem`=0, `rob_next_index`=5. Expect next cycle: `rs_valid`=1, `lsb_valid`=0, `iss_val1/2`=0x10/0x20, both `has_dep`=0, `rf_regrename`=5.
- **ROB stall:** `rob_full`=1 with `in_valid`=1. Expect `in_ready`=0 and no strobes. When `rob_full` drops, expect the instruction to dispatch one cycle later.
- **CDB bypass:** `rf_has_dep1`=1, `rf_dep1`=7, `rob_value_valid1`=0, `cdb_valid`=1, `cdb_rob_index`=7, `cdb_value`=0xABCD. Expect `iss_val1`=0xABCD, `iss_has_dep1`=0, `iss_dep1`=0.
- **Unresolved dependency:** same as above but `cdb_rob_index`=9. Expect `iss_has_dep1`=1, `iss_dep1`=7, `iss_val1`=0.
- **Store to LSB with x0 handling:** `in_is_mem`=1, `in_writes_rd`=0, rs1=0 while `rf_has_dep1`=1. Expect `lsb_valid`=1, `rf_valid`=0, `iss_val1`=0, `iss_has_dep1`=0.
- **Flush, freeze and reset:** `flush`=1 together with `in_valid`=1 → no strobes next cycle. `rdy`=0 for 3 cycles after a fire → strobes held high throughout. `rst` for one cycle → all outputs 0.
